// File: rtl/ysyx_22051013_div_issue.sv
// ysyx_22051013_div_issue
// Requester-side controller for the 64-cycle iterative divider. Divide-by-zero
// and signed overflow are answered locally; every other op is sent to the
// divider with a single request pulse. Operands are held in registers until
// the divider strobes its result, and the W-adjusted result goes back to EXU.
module ysyx_22051013_div_issue #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_div_en,
  input  logic [2:0]    ex_div_op,
  input  logic [DW-1:0] ex_src1,
  input  logic [DW-1:0] ex_src2,
  input  logic          flush,
  input  logic          div_ready,
  input  logic          div_out_valid,
  input  logic [DW-1:0] div_quotient,
  input  logic [DW-1:0] div_remainder,
  output logic          div_valid,
  output logic          div_flush,
  output logic          div_signed,
  output logic          div_w,
  output logic [DW-1:0] div_op1,
  output logic [DW-1:0] div_op2,
  output logic          ex_stall,
  output logic          res_valid,
  output logic [DW-1:0] res_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          signed_r;
  logic          rem_r;
  logic          w_r;
  logic [DW-1:0] src1_r;
  logic [DW-1:0] src2_r;
  logic [DW-1:0] res_r;

  logic          accept_s;
  logic          div0_s;
  logic          ovf_s;
  logic          special_s;
  logic [DW-1:0] bypass_raw_s;
  logic [DW-1:0] bypass_s;
  logic          load_res_s;
  logic [DW-1:0] res_nxt_s;

  // W results (including DIVUW/REMUW) are always sign-extended from bit 31.
  function automatic logic [DW-1:0] w_adjust(input logic is_w, input logic [DW-1:0] val);
    logic [DW-1:0] out;
    if (is_w) begin
      out = {{(DW-32){val[31]}}, val[31:0]};
    end else begin
      out = val;
    end
    return out;
  endfunction

  assign accept_s = (state_r == IDLE) & ex_div_en & ~flush;

  // Detect divide-by-zero / signed overflow on the incoming op and form its bypass result.
  always_comb begin
    div0_s       = 1'b0;
    ovf_s        = 1'b0;
    bypass_raw_s = {DW{1'b0}};
    if (ex_div_op[2]) begin
      div0_s = (ex_src2[31:0] == 32'h0000_0000);
      ovf_s  = ~ex_div_op[0] & (ex_src1[31:0] == 32'h8000_0000)
                             & (ex_src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      div0_s = (ex_src2 == {DW{1'b0}});
      ovf_s  = ~ex_div_op[0] & (ex_src1 == {1'b1, {(DW-1){1'b0}}})
                             & (ex_src2 == {DW{1'b1}});
    end
    special_s = div0_s | ovf_s;
    if (ex_div_op[1]) begin
      bypass_raw_s = div0_s ? ex_src1 : {DW{1'b0}};
    end else begin
      bypass_raw_s = div0_s ? {DW{1'b1}} : ex_src1;
    end
    bypass_s = w_adjust(ex_div_op[2], bypass_raw_s);
  end

  // Next state and result-register load; flush overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    load_res_s  = 1'b0;
    res_nxt_s   = res_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (ex_div_en) begin
            if (special_s) begin
              state_nxt_s = RESP;
              load_res_s  = 1'b1;
              res_nxt_s   = bypass_s;
            end else begin
              state_nxt_s = ISSUE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ISSUE: begin
          if (div_ready) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = ISSUE;
          end
        end
        WAIT: begin
          if (div_out_valid) begin
            state_nxt_s = RESP;
            load_res_s  = 1'b1;
            res_nxt_s   = w_adjust(w_r, rem_r ? div_remainder : div_quotient);
          end else begin
            state_nxt_s = WAIT;
          end
        end
        RESP:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the op and operands when a request is accepted; they stay put until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_r <= 1'b0;
      rem_r    <= 1'b0;
      w_r      <= 1'b0;
      src1_r   <= {DW{1'b0}};
      src2_r   <= {DW{1'b0}};
    end else if (accept_s) begin
      signed_r <= ~ex_div_op[0];
      rem_r    <= ex_div_op[1];
      w_r      <= ex_div_op[2];
      src1_r   <= ex_src1;
      src2_r   <= ex_src2;
    end
  end

  // Result register: loaded from the bypass path or the divider, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_r <= {DW{1'b0}};
    end else if (load_res_s) begin
      res_r <= res_nxt_s;
    end
  end

  assign div_valid  = (state_r == ISSUE) & div_ready & ~flush;
  assign div_flush  = flush & ((state_r == ISSUE) | (state_r == WAIT));
  assign div_signed = signed_r;
  assign div_w      = w_r;
  assign div_op1    = src1_r;
  assign div_op2    = src2_r;
  assign ex_stall   = ~rst & (((state_r == IDLE) & ex_div_en & ~flush)
                            | (state_r == ISSUE) | (state_r == WAIT));
  assign res_valid  = (state_r == RESP) & ~flush;
  assign res_data   = res_r;

endmodule

// File: tb/tb_ysyx_22051013_div_issue.sv
// Self-checking bench for ysyx_22051013_div_issue: a transaction-level model of
// the request lifecycle plus an arithmetic reference for RV64M div/rem results,
// a simple 64-cycle divider stand-in, directed cases and a random phase.
module tb_ysyx_22051013_div_issue;

  typedef enum int {T_NONE, T_QUEUED, T_IN_DIV, T_DONE} tstat_t;

  logic        clk;
  logic        rst;
  logic        ex_div_en;
  logic [2:0]  ex_div_op;
  logic [63:0] ex_src1;
  logic [63:0] ex_src2;
  logic        flush;
  logic        div_ready;
  logic        div_out_valid;
  logic [63:0] div_quotient;
  logic [63:0] div_remainder;
  logic        div_valid;
  logic        div_flush;
  logic        div_signed;
  logic        div_w;
  logic [63:0] div_op1;
  logic [63:0] div_op2;
  logic        ex_stall;
  logic        res_valid;
  logic [63:0] res_data;

  ysyx_22051013_div_issue #(.DW(64)) dut (
    .clk(clk), .rst(rst), .ex_div_en(ex_div_en), .ex_div_op(ex_div_op),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .flush(flush), .div_ready(div_ready),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_valid(div_valid), .div_flush(div_flush),
    .div_signed(div_signed), .div_w(div_w), .div_op1(div_op1), .div_op2(div_op2),
    .ex_stall(ex_stall), .res_valid(res_valid), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  tstat_t      ts;
  logic [2:0]  t_op;
  logic [63:0] t_s1;
  logic [63:0] t_s2;
  logic [63:0] t_res;
  logic [63:0] m_hold;
  int          dv_cnt;
  logic        dv_strobe;
  logic [63:0] dv_q;
  logic [63:0] dv_r;
  logic        o_dv, o_df, o_st, o_rv, o_sg, o_w;
  logic [63:0] o_res, o_op1, o_op2;

  // RV64M reference: returns {special, result} straight from the ISA rules.
  function automatic logic [64:0] ref_div(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] q32, r32;
    logic [63:0] q, r;
    logic        sp;
    int          wa, wb;
    longint      sa, sb;
    sp = 1'b0;
    if (op[2]) begin
      wa = $signed(a[31:0]);
      wb = $signed(b[31:0]);
      if (b[31:0] == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a[31:0]; sp = 1'b1;
      end else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = 32'd0; sp = 1'b1;
      end else if (!op[0]) begin
        q32 = 32'(wa / wb); r32 = 32'(wa % wb);
      end else begin
        q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; sp = 1'b1;
      end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0; sp = 1'b1;
      end else if (!op[0]) begin
        q = 64'(sa / sb); r = 64'(sa % sb);
      end else begin
        q = a / b; r = a % b;
      end
    end
    return {sp, op[1] ? r : q};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_div_valid"}, 64'(div_valid), 64'd0);
    chk({pfx, "_div_flush"}, 64'(div_flush), 64'd0);
    chk({pfx, "_ex_stall"},  64'(ex_stall),  64'd0);
    chk({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({pfx, "_res_data"},  res_data,       64'd0);
    chk({pfx, "_div_op1"},   div_op1,        64'd0);
    chk({pfx, "_div_op2"},   div_op2,        64'd0);
    chk({pfx, "_div_signed"}, 64'(div_signed), 64'd0);
    chk({pfx, "_div_w"},     64'(div_w),     64'd0);
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance model and divider stand-in.
  task automatic step(input logic en, input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                      input logic fl, input logic hold, input logic inj);
    logic        exp_dv, exp_df, exp_st, exp_rv, busy;
    logic [64:0] tmp;
    @(negedge clk);
    dv_strobe = 1'b0;
    if (dv_cnt != 0) begin
      dv_cnt = dv_cnt - 1;
      if (dv_cnt == 0) dv_strobe = 1'b1;
    end
    div_out_valid = dv_strobe | inj;
    div_quotient  = dv_q;
    div_remainder = dv_r;
    div_ready     = (dv_cnt == 0) && !hold;
    ex_div_en = en; ex_div_op = op; ex_src1 = s1; ex_src2 = s2; flush = fl;
    #1;
    o_dv = div_valid; o_df = div_flush; o_st = ex_stall; o_rv = res_valid;
    o_sg = div_signed; o_w = div_w; o_res = res_data; o_op1 = div_op1; o_op2 = div_op2;

    busy   = (ts == T_QUEUED) || (ts == T_IN_DIV);
    exp_dv = (ts == T_QUEUED) && div_ready && !fl;
    exp_df = fl && busy;
    exp_st = ((ts == T_NONE) && en && !fl) || busy;
    exp_rv = (ts == T_DONE) && !fl;
    chk("div_valid", 64'(o_dv), 64'(exp_dv));
    chk("div_flush", 64'(o_df), 64'(exp_df));
    chk("ex_stall",  64'(o_st), 64'(exp_st));
    chk("res_valid", 64'(o_rv), 64'(exp_rv));
    chk("res_data",  o_res, m_hold);
    if (busy) begin
      chk("div_op1",    o_op1, t_s1);
      chk("div_op2",    o_op2, t_s2);
      chk("div_signed", 64'(o_sg), 64'(!t_op[0]));
      chk("div_w",      64'(o_w),  64'(t_op[2]));
    end

    if (fl) begin
      ts = T_NONE;
    end else begin
      case (ts)
        T_NONE: if (en) begin
          t_op = op; t_s1 = s1; t_s2 = s2;
          tmp = ref_div(op, s1, s2);
          t_res = tmp[63:0];
          if (tmp[64]) begin ts = T_DONE; m_hold = t_res; end
          else ts = T_QUEUED;
        end
        T_QUEUED: if (div_ready) ts = T_IN_DIV;
        T_IN_DIV: if (div_out_valid) begin ts = T_DONE; m_hold = t_res; end
        T_DONE:   ts = T_NONE;
        default:  ts = T_NONE;
      endcase
    end

    if (o_df) begin
      dv_cnt = 0;
    end else if (o_dv) begin
      dv_cnt = 65;
      tmp  = ref_div({o_w, 1'b0, ~o_sg}, o_op1, o_op2);
      dv_q = tmp[63:0];
      tmp  = ref_div({o_w, 1'b1, ~o_sg}, o_op1, o_op2);
      dv_r = tmp[63:0];
      if (o_w) begin
        dv_q[63:32] = $urandom;
        dv_r[63:32] = $urandom;
      end
    end
  endtask

  task automatic idle_step(input logic hold, input logic inj);
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, hold, inj);
  endtask

  // Present one op, then wait (bounded) for its response.
  task automatic run_op(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                        output int lat, output logic [63:0] res, output int ndv,
                        output int dv_at, output int gaps);
    step(1'b1, op, s1, s2, 1'b0, 1'b0, 1'b0);
    chk("accept_stall", 64'(o_st), 64'd1);
    lat = -1; ndv = 0; dv_at = -1; gaps = 0; res = 64'd0;
    for (int i = 1; i <= 200; i++) begin
      idle_step(1'b0, 1'b0);
      if (o_dv) begin ndv = ndv + 1; dv_at = i; end
      if (o_rv) begin
        lat = i; res = o_res;
        chk("resp_stall_low", 64'(o_st), 64'd0);
        break;
      end
      if (!o_st) gaps = gaps + 1;
    end
  endtask

  int          lat, ndv, dv_at, gaps;
  logic [63:0] res;
  logic [64:0] pin;
  logic        r_en, r_fl, r_hold;
  logic [2:0]  r_op;
  logic [63:0] r_s1, r_s2;

  // Stimulus and directed checks.
  initial begin
    n_vec = 0; n_err = 0;
    ts = T_NONE; m_hold = 64'd0; dv_cnt = 0; dv_q = 64'd0; dv_r = 64'd0;
    t_op = 3'd0; t_s1 = 64'd0; t_s2 = 64'd0; t_res = 64'd0;
    rst = 1'b1; ex_div_en = 1'b0; ex_div_op = 3'd0; ex_src1 = 64'd0; ex_src2 = 64'd0;
    flush = 1'b0; div_ready = 1'b1; div_out_valid = 1'b0;
    div_quotient = 64'd0; div_remainder = 64'd0;

    // pin the reference model with hand-computed values
    pin = ref_div(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    chk("ref_div_m7_2", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFD);
    pin = ref_div(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    chk("ref_rem_m7_2", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    pin = ref_div(3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    chk("ref_divw_ovf", pin[63:0], 64'hFFFF_FFFF_8000_0000);
    pin = ref_div(3'b111, 64'h0000_0000_8000_0005, 64'h1234_0000_0000_0000);
    chk("ref_remuw_div0", pin[63:0], 64'hFFFF_FFFF_8000_0005);

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // DIVU 100/7 with an idle divider
    run_op(3'b001, 64'd100, 64'd7, lat, res, ndv, dv_at, gaps);
    chk("divu_lat", 64'(lat), 64'd67);
    chk("divu_res", res, 64'd14);
    chk("divu_ndv", 64'(ndv), 64'd1);
    chk("divu_dv_at", 64'(dv_at), 64'd1);
    chk("divu_stall_gaps", 64'(gaps), 64'd0);

    // REMW -7 % 2 with upper garbage from the divider
    run_op(3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2, lat, res, ndv, dv_at, gaps);
    chk("remw_lat", 64'(lat), 64'd67);
    chk("remw_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("remw_op1_hold", o_op1, 64'h0000_0000_FFFF_FFF9);

    // bypass cases
    run_op(3'b000, 64'd5, 64'd0, lat, res, ndv, dv_at, gaps);
    chk("div0_lat", 64'(lat), 64'd1);
    chk("div0_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div0_ndv", 64'(ndv), 64'd0);
    run_op(3'b010, 64'd5, 64'd0, lat, res, ndv, dv_at, gaps);
    chk("rem0_res", res, 64'd5);
    run_op(3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res, ndv, dv_at, gaps);
    chk("ovf_lat", 64'(lat), 64'd1);
    chk("ovf_div_res", res, 64'h8000_0000_0000_0000);
    chk("ovf_ndv", 64'(ndv), 64'd0);
    run_op(3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res, ndv, dv_at, gaps);
    chk("ovf_rem_res", res, 64'd0);

    // DIVUW result is sign-extended too
    run_op(3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, lat, res, ndv, dv_at, gaps);
    chk("divuw_res", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // flush mid-divide, then a new op against a busy divider and a stale strobe
    step(1'b1, 3'b000, 64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) idle_step(1'b0, 1'b0);
    step(1'b0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_div_flush", 64'(o_df), 64'd1);
    chk("flush_no_res", 64'(o_rv), 64'd0);
    idle_step(1'b0, 1'b0);
    chk("post_flush_idle", 64'(o_st), 64'd0);
    step(1'b1, 3'b010, 64'd1000, 64'd7, 1'b0, 1'b1, 1'b0);
    chk("held_accept_dv", 64'(o_dv), 64'd0);
    idle_step(1'b1, 1'b1);
    chk("stale_strobe_dv", 64'(o_dv), 64'd0);
    chk("stale_strobe_rv", 64'(o_rv), 64'd0);
    idle_step(1'b1, 1'b0);
    chk("held_dv", 64'(o_dv), 64'd0);
    idle_step(1'b0, 1'b0);
    chk("release_dv", 64'(o_dv), 64'd1);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      idle_step(1'b0, 1'b0);
      if (o_rv) begin lat = i; res = o_res; break; end
    end
    chk("after_flush_lat", 64'(lat), 64'd66);
    chk("after_flush_res", res, 64'd6);

    // asynchronous reset in the middle of an op
    step(1'b1, 3'b000, 64'd12345, 64'd17, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 30; i++) idle_step(1'b0, 1'b0);
    @(negedge clk);
    #3;
    chk("pre_rst_stall", 64'(ex_stall), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    ts = T_NONE; m_hold = 64'd0; dv_cnt = 0;
    rst = 1'b0;
    idle_step(1'b0, 1'b1);

    // random phase
    for (int i = 0; i < 5000; i++) begin
      r_en   = ($urandom_range(0, 2) == 0);
      r_op   = 3'($urandom_range(0, 7));
      r_fl   = ($urandom_range(0, 299) == 0);
      r_hold = ($urandom_range(0, 3) == 0);
      r_s1   = {$urandom, $urandom};
      r_s2   = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: r_s2 = 64'd0;
        1: begin r_s1 = 64'h8000_0000_0000_0000; r_s2 = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: begin r_s1[31:0] = 32'h8000_0000; r_s2[31:0] = 32'hFFFF_FFFF; end
        3: r_s2 = 64'($urandom_range(1, 9));
        4: r_s2[31:0] = 32'd0;
        default: ;
      endcase
      step(r_en, r_op, r_s1, r_s2, r_fl, r_hold, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
